// File: rtl/btn_event_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button event controller:
//   id_w()      - index width needed to address n_btn buttons (minimum 1)
//   btn_evt_t   - one button event record {id, press}; id is sized for the
//                 largest supported button count, the top slices it down
//   evt_fsm_e   - output stage state encoding (EMPTY=0, FULL=1)
// ----------------------------------------------------------------------------
package btn_pkg;

    localparam int MAX_BTN  = 16;
    localparam int MAX_ID_W = 4;

    // Width of a button index; a single button still gets one bit.
    function automatic int id_w(input int n_btn);
        return (n_btn <= 2) ? 1 : $clog2(n_btn);
    endfunction

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic                press;
    } btn_evt_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } evt_fsm_e;

endpackage

// File: rtl/btn_event_ctrl_if.sv
// ----------------------------------------------------------------------------
// btn_event_ctrl_if
// Valid/ready event channel carrying one button event per transfer.
//   evt_valid  producer -> consumer  event available
//   evt_ready  consumer -> producer  event accepted this cycle
//   evt_id     producer -> consumer  button index
//   evt_press  producer -> consumer  1 = press, 0 = release
// ----------------------------------------------------------------------------
interface btn_event_ctrl_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_press;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_press,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_press,
        output evt_ready
    );
endinterface

// File: rtl/btn_event_ctrl_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at last_id+1
// (mod N) and the first requesting position wins.
//   req       N-bit request vector
//   last_id   index granted most recently
//   grant     one-hot grant (all zero when nothing requests)
//   grant_id  index of the granted position (0 when nothing requests)
//   any       at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_id,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_id,
    output logic             any
);

    int   pos_s;
    logic found_s;
    logic hit_s;

    // Walk positions in priority order last_id+1 .. last_id+N and take the first request.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found_s  = 1'b0;
        pos_s    = 0;
        hit_s    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            pos_s = int'(last_id) + k;
            pos_s = (pos_s >= N) ? (pos_s - N) : pos_s;
            for (int j = 0; j < N; j++) begin
                hit_s    = !found_s && req[j] && (j == pos_s);
                grant[j] = grant[j] | hit_s;
                grant_id = hit_s ? IDX_W'(j) : grant_id;
                found_s  = found_s | hit_s;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// ----------------------------------------------------------------------------
// btn_event_ctrl
// Multi-button debounce controller. Raw pins are synchronized, debounced
// against a shared sample-tick prescaler and turned into press/release events
// delivered one at a time over a valid/ready channel with round-robin
// arbitration between buttons.
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   btn_raw    raw pin levels (asynchronous), 1 = pressed
//   btn_state  debounced levels
//   evt_ovf    sticky: a pending, unreported event was overwritten
//   ovf_clr    synchronous clear of evt_ovf (a same-cycle overflow wins)
//   evt        event channel (master side)
// ----------------------------------------------------------------------------
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int N_BTN    = 4,
    parameter int TICK_DIV = 1000,
    parameter int DWELL    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_state,
    output logic             evt_ovf,
    input  logic             ovf_clr,
    btn_event_ctrl_if.master evt
);

    localparam int ID_W   = id_w(N_BTN);
    localparam int PCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DCNT_W = $clog2(DWELL + 1);

    localparam logic [PCNT_W-1:0]   PCNT_LAST   = PCNT_W'(TICK_DIV - 1);
    localparam logic [DCNT_W-1:0]   DCNT_LAST   = DCNT_W'(DWELL - 1);
    localparam logic [MAX_ID_W-1:0] LAST_ID_RST = MAX_ID_W'(N_BTN - 1);

    logic [N_BTN-1:0]    sync1_r;
    logic [N_BTN-1:0]    sync2_r;
    logic [N_BTN-1:0]    state_r;
    logic [N_BTN-1:0]    pend_r;
    logic [N_BTN-1:0]    pdir_r;
    logic [N_BTN-1:0]    accept_s;
    logic [N_BTN-1:0]    grant_s;
    logic [N_BTN-1:0]    load_grant_s;
    logic [PCNT_W-1:0]   pcnt_r;
    logic                tick_s;
    logic [DCNT_W-1:0]   dcnt_r     [N_BTN];
    logic [DCNT_W-1:0]   dcnt_nxt_s [N_BTN];
    logic [MAX_ID_W-1:0] grant_id_s;
    logic [MAX_ID_W-1:0] last_id_s;
    logic                req_any_s;
    logic                rr_init_r;
    evt_fsm_e            fsm_r;
    evt_fsm_e            fsm_nxt_s;
    logic                load_s;
    btn_evt_t            evt_r;
    btn_evt_t            evt_nxt_s;
    logic                evt_valid_r;
    logic                ovf_r;
    logic                ovf_set_s;

    // Two-flop synchronizer for every raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    assign tick_s = (pcnt_r == PCNT_LAST);

    // Shared sample-tick prescaler, counts 0..TICK_DIV-1 and wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_r <= '0;
        end else if (tick_s) begin
            pcnt_r <= '0;
        end else begin
            pcnt_r <= pcnt_r + PCNT_W'(1);
        end
    end

    // Dwell counters: a level is accepted on the DWELL-th consecutive mismatching tick.
    always_comb begin
        accept_s = '0;
        for (int i = 0; i < N_BTN; i++) begin
            dcnt_nxt_s[i] = dcnt_r[i];
        end
        if (tick_s) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2_r[i] == state_r[i]) begin
                    dcnt_nxt_s[i] = '0;
                end else if (dcnt_r[i] == DCNT_LAST) begin
                    dcnt_nxt_s[i] = '0;
                    accept_s[i]   = 1'b1;
                end else begin
                    dcnt_nxt_s[i] = dcnt_r[i] + DCNT_W'(1);
                end
            end
        end else begin
            accept_s = '0;
        end
    end

    // Debounced level, dwell counters, pending flags and pending direction.
    // An acceptance beats a same-cycle load of the same button: pend stays set
    // with the new direction while the loaded event keeps the old one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= '0;
            pend_r  <= '0;
            pdir_r  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt_r[i] <= '0;
            end
        end else begin
            state_r <= state_r ^ accept_s;
            pend_r  <= (pend_r & ~load_grant_s) | accept_s;
            pdir_r  <= (pdir_r & ~accept_s) | (sync2_r & accept_s);
            for (int i = 0; i < N_BTN; i++) begin
                dcnt_r[i] <= dcnt_nxt_s[i];
            end
        end
    end

    // Round-robin pointer: until the first load the search starts at button 0.
    always_comb begin
        if (rr_init_r) begin
            last_id_s = LAST_ID_RST;
        end else begin
            last_id_s = evt_r.id;
        end
    end

    rr_arbiter #(
        .N     (N_BTN),
        .IDX_W (MAX_ID_W)
    ) u_rr_arbiter (
        .req      (pend_r),
        .last_id  (last_id_s),
        .grant    (grant_s),
        .grant_id (grant_id_s),
        .any      (req_any_s)
    );

    // Output stage next state: load when empty, or reload on a transfer.
    always_comb begin
        fsm_nxt_s = fsm_r;
        load_s    = 1'b0;
        case (fsm_r)
            ST_EMPTY: begin
                if (req_any_s) begin
                    load_s    = 1'b1;
                    fsm_nxt_s = ST_FULL;
                end else begin
                    fsm_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (evt.evt_ready) begin
                    if (req_any_s) begin
                        load_s    = 1'b1;
                        fsm_nxt_s = ST_FULL;
                    end else begin
                        fsm_nxt_s = ST_EMPTY;
                    end
                end else begin
                    fsm_nxt_s = ST_FULL;
                end
            end
            default: begin
                fsm_nxt_s = ST_EMPTY;
            end
        endcase
    end

    assign load_grant_s    = load_s ? grant_s : '0;
    assign evt_nxt_s.id    = grant_id_s;
    assign evt_nxt_s.press = |(pdir_r & grant_s);

    // An overwrite only counts when the pending event is not being reported this cycle.
    assign ovf_set_s = |(accept_s & pend_r & ~load_grant_s);

    // Output stage state, event register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= ST_EMPTY;
            evt_valid_r <= 1'b0;
            evt_r       <= '0;
            rr_init_r   <= 1'b1;
        end else begin
            fsm_r       <= fsm_nxt_s;
            evt_valid_r <= (fsm_nxt_s == ST_FULL);
            if (load_s) begin
                evt_r     <= evt_nxt_s;
                rr_init_r <= 1'b0;
            end
        end
    end

    // Sticky overflow flag; a new overflow beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end
    end

    assign btn_state     = state_r;
    assign evt_ovf       = ovf_r;
    assign evt.evt_valid = evt_valid_r;
    assign evt.evt_id    = evt_r.id[ID_W-1:0];
    assign evt.evt_press = evt_r.press;

endmodule
